// File: rtl/emux_tx2.sv
// emux_tx2: two-client round-robin TX mux emitting header, payload, CRC marker and idle gap.
// Optional macro EMUX_TX_PAD_EN pads payloads shorter than 18 bytes with zero bytes.
module emux_tx2 #(
  parameter logic [15:0] port1  = 16'd0,
  parameter logic [15:0] port2  = 16'd0,
  parameter int          len_dw = 11,
  parameter int          gap    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [len_dw-1:0] len0,
  input  logic [len_dw-1:0] len1,
  output logic [1:0]        grant,
  output logic              rd,
  input  logic [7:0]        d0,
  input  logic [7:0]        d1,
  input  logic              out_hold,
  output logic              out_s,
  output logic [7:0]        out_d,
  output logic              out_crc,
  output logic              busy
);
  localparam int GW = (gap > 1) ? $clog2(gap) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_EOF, S_GAP} state_t;
  typedef enum logic [1:0] {K_HDR, K_DAT, K_PAD, K_CRC} kind_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              cli_q, cli_d;
  logic              last_q, last_d;
  logic [len_dw-1:0] len_q, len_d;
  logic [len_dw-1:0] rem_q, rem_d;
  logic [15:0]       port_q, port_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
`ifdef EMUX_TX_PAD_EN
  logic [4:0]        pad_q, pad_d;
`endif

  logic              pick;
  logic [len_dw-1:0] len_sel;
  logic [15:0]       len16;
  logic              pad_left, body_last;

  logic              slot_v;
  kind_t             slot_k;
  logic [7:0]        slot_b;
  logic              rd_c;

  logic              vld_p1_q;
  kind_t             kind_p1_q;
  logic [7:0]        byte_p1_q;

  logic              out_s_q, out_s_d;
  logic              out_crc_q, out_crc_d;
  logic [7:0]        out_d_q, out_d_d;

  // Both requesting: serve the client that was not served last.
  assign pick    = (req == 2'b11) ? ~last_q : req[1];
  assign len_sel = pick ? len1 : len0;
  assign len16   = 16'(len_q);

`ifdef EMUX_TX_PAD_EN
  assign pad_left  = (pad_q != 5'd0);
  assign body_last = ((rem_q == len_dw'(1)) && !pad_left) ||
                     ((rem_q == '0) && (pad_q == 5'd1));
`else
  assign pad_left  = 1'b0;
  assign body_last = (rem_q == len_dw'(1));
`endif

  // Stage p0: frame FSM and slot issue
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cli_d   = cli_q;
    last_d  = last_q;
    len_d   = len_q;
    rem_d   = rem_q;
    port_d  = port_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
`ifdef EMUX_TX_PAD_EN
    pad_d   = pad_q;
`endif
    slot_v  = 1'b0;
    slot_k  = K_HDR;
    slot_b  = 8'h00;
    rd_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          cli_d   = pick;
          last_d  = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          len_d   = len_sel;
          rem_d   = len_sel;
          port_d  = pick ? port2 : port1;
          hcnt_d  = 2'd0;
`ifdef EMUX_TX_PAD_EN
          pad_d   = (32'(len_sel) < 32'd18) ? 5'(32'd18 - 32'(len_sel)) : 5'd0;
`endif
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!out_hold) begin
          slot_v = 1'b1;
          slot_k = K_HDR;
          case (hcnt_q)
            2'd0:    slot_b = port_q[15:8];
            2'd1:    slot_b = port_q[7:0];
            2'd2:    slot_b = len16[15:8];
            default: slot_b = len16[7:0];
          endcase
          hcnt_d = hcnt_q + 2'd1;
          if (hcnt_q == 2'd3) state_d = ((rem_q != '0) || pad_left) ? S_BODY : S_EOF;
        end
      end
      S_BODY: begin
        if (!out_hold) begin
          slot_v = 1'b1;
          if (rem_q != '0) begin
            slot_k = K_DAT;
            rd_c   = 1'b1;
            rem_d  = rem_q - len_dw'(1);
          end else begin
            slot_k = K_PAD;
          end
`ifdef EMUX_TX_PAD_EN
          if (rem_q == '0) pad_d = pad_q - 5'd1;
`endif
          if (body_last) state_d = S_EOF;
        end
      end
      S_EOF: begin
        if (!out_hold) begin
          slot_v  = 1'b1;
          slot_k  = K_CRC;
          grant_d = 2'b00;
          gcnt_d  = GW'(gap - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) state_d = S_IDLE;
        else              gcnt_d  = gcnt_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1 -> output: payload byte arrives the cycle after rd, header byte is delayed to match
  always_comb begin
    out_s_d   = vld_p1_q && (kind_p1_q != K_CRC);
    out_crc_d = vld_p1_q && (kind_p1_q == K_CRC);
    out_d_d   = 8'h00;
    if (vld_p1_q) begin
      case (kind_p1_q)
        K_HDR:   out_d_d = byte_p1_q;
        K_DAT:   out_d_d = cli_q ? d1 : d0;
        default: out_d_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      cli_q     <= 1'b0;
      last_q    <= 1'b1;
      rem_q     <= '0;
      hcnt_q    <= 2'd0;
      gcnt_q    <= '0;
`ifdef EMUX_TX_PAD_EN
      pad_q     <= 5'd0;
`endif
      vld_p1_q  <= 1'b0;
      out_s_q   <= 1'b0;
      out_crc_q <= 1'b0;
      out_d_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cli_q     <= cli_d;
      last_q    <= last_d;
      rem_q     <= rem_d;
      hcnt_q    <= hcnt_d;
      gcnt_q    <= gcnt_d;
`ifdef EMUX_TX_PAD_EN
      pad_q     <= pad_d;
`endif
      vld_p1_q  <= slot_v;
      out_s_q   <= out_s_d;
      out_crc_q <= out_crc_d;
      out_d_q   <= out_d_d;
    end
    len_q     <= len_d;
    port_q    <= port_d;
    kind_p1_q <= slot_k;
    byte_p1_q <= slot_b;
  end

  assign grant   = grant_q;
  assign rd      = rd_c;
  assign out_s   = out_s_q;
  assign out_d   = out_d_q;
  assign out_crc = out_crc_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/emux_tx2.md
Name: emux_tx2

Overview:
- Two-client transmit multiplexer for the UDP packet path, feeding the Ethernet TX framer.
- Arbitrates between two clients with round-robin priority.
- Per frame, emits a 4-byte client header (16-bit source port, 16-bit payload length), then the client's payload read out byte by byte.
- Ends each frame with a one-cycle CRC-append marker, then enforces an idle gap before the next frame.

Parameters:
- port1, 16'd0, source port inserted for client 0
- port2, 16'd0, source port inserted for client 1
- len_dw, 11, payload length width; max payload 2^len_dw-1
- gap, 12, minimum idle cycles between out_crc and the next frame's first byte (must be ≥1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active high
- req  input  2  per-client frame request (level)
- len0  input  len_dw  client 0 payload length, sampled at grant
- len1  input  len_dw  client 1 payload length, sampled at grant
- grant  output  2  one-hot, high for the whole frame
- rd  output  1  payload byte read strobe to the granted client
- d0  input  8  client 0 byte, valid the cycle after rd
- d1  input  8  client 1 byte, valid the cycle after rd
- out_hold  input  1  downstream stall; no slot issued while high
- out_s  output  1  byte strobe
- out_d  output  8  byte data
- out_crc  output  1  one-cycle end-of-frame / append-CRC pulse
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values: grant, rd, out_s, out_d, out_crc, busy all 0. State IDLE, round-robin pointer favours client 0.
- Reset mid-frame: outputs go to 0 the next cycle and any in-flight pipeline is discarded. out_crc is never issued for the abandoned frame.
- States: IDLE → HDR → BODY → EOF → GAP → IDLE.
- IDLE:
  - If any req is high: grant the requester. If both are high, grant the client other than the last served.
  - Latch that client's len and port, then go to HDR.
  - grant asserts the cycle after the decision.
- HDR:
  - Issues 4 slots: port[15:8], port[7:0], len16[15:8], len16[7:0].
  - len16 is len zero-extended to 16 bits.
- BODY:
  - Issues len slots. Each slot asserts rd for one cycle; the granted d is captured the next cycle.
  - len==0 skips BODY entirely.
- EOF:
  - Issues one CRC slot, then drops grant the following cycle.
  - Loads the gap counter with gap-1.
- GAP:
  - Counts down to 0, then returns to IDLE.
  - out_hold has no effect in GAP.
- Slot issue: at most one slot per cycle, and only when out_hold==0. out_hold freezes the slot counters; slots already issued still complete.
- Fixed latency, header and payload alike: a slot issued in cycle n produces out_s=1 with out_d in cycle n+2.
  - Header bytes travel through a 2-stage delay matched to the rd→d→register path.
- out_crc: asserted with out_s=0 at n+2 for the EOF slot. This is exactly the cycle after the last byte when there is no stall.
- Back-to-back frames: first header byte of the next frame comes no earlier than gap+1 cycles after out_crc.
- req sampling: req is sampled only in IDLE. A req still high when GAP ends starts a new frame. Clients drop req after seeing grant.
- Length counter: len_dw bits, decrements per payload slot. The max len (all ones) must not wrap.

Optional Feature:
- Macro: EMUX_TX_PAD_EN.
- Defined: if len<18, BODY issues 18 slots in total. Slots beyond len carry 0x00 and do not assert rd. The header length field still reports the original len.
- Undefined: no padding; exactly len payload bytes.

Test Plan:
- port1=16'h1234, req=2'b01, len0=3, d0 sequence A1,A2,A3 → out bytes 12,34,00,03,A1,A2,A3 on consecutive cycles. out_crc on the next cycle; rd exactly 3 pulses.
- req=2'b11 held, len0=len1=1, port2=16'h5678 → frames alternate client 0, client 1, client 0. The first header byte of the next frame comes no earlier than 13 cycles after out_crc (gap=12).
- len1=0, client 1 alone → out 56,78,00,00 then out_crc. rd never asserted.
- out_hold pulsed high for 3 cycles mid-BODY, len0=5 → 5 payload bytes in order with a 3-cycle hole, no duplication or loss, header intact.
- rst asserted during BODY of a len0=100 frame → next cycle grant=0, out_s=0, busy=0, no out_crc. A new req then gives a full frame starting at the header.
- With EMUX_TX_PAD_EN, len0=2 → header 00,02, then 2 client bytes plus 16 zero bytes, 2 rd pulses, then out_crc.
